// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU and a debug port.
// CPU wins by default; a starvation counter forces a debug slot after STARVE_LIM lost cycles.
module dmem_arbiter #(
    parameter int AW         = 18,
    parameter int DW         = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam logic [3:0] LIM = 4'(STARVE_LIM);
    logic [3:0]    starve_cnt;
    logic          gnt_cpu, gnt_dbg, rd_own_cpu, rd_own_dbg;
    logic [DW-1:0] cpu_hold, dbg_hold;
    always_comb begin
        gnt_dbg   = !rst & dbg_req & (!cpu_req | starve_cnt == LIM);
        gnt_cpu   = !rst & cpu_req & !gnt_dbg;
        cpu_stall = cpu_req & !gnt_cpu;
        dbg_gnt   = gnt_dbg;
        mem_en    = gnt_cpu | gnt_dbg;
        mem_we    = gnt_cpu ? cpu_we    : gnt_dbg & dbg_we;
        mem_addr  = gnt_cpu ? cpu_addr  : gnt_dbg ? dbg_addr  : '0;
        mem_wdata = gnt_cpu ? cpu_wdata : gnt_dbg ? dbg_wdata : '0;
        // Read data is live on the rvalid cycle and held in a register afterwards.
        cpu_rvalid = rd_own_cpu;
        dbg_rvalid = rd_own_dbg;
        cpu_rdata  = rd_own_cpu ? mem_rdata : cpu_hold;
        dbg_rdata  = rd_own_dbg ? mem_rdata : dbg_hold;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            rd_own_cpu <= 1'b0;
            rd_own_dbg <= 1'b0;
            cpu_hold   <= '0;
            dbg_hold   <= '0;
        end else begin
            starve_cnt <= (!dbg_req || gnt_dbg) ? 4'd0 : (starve_cnt == LIM) ? LIM : starve_cnt + 4'd1;
            rd_own_cpu <= gnt_cpu & !cpu_we;
            rd_own_dbg <= gnt_dbg & !dbg_we;
            if (rd_own_cpu) cpu_hold <= mem_rdata;
            if (rd_own_dbg) dbg_hold <= mem_rdata;
        end
    end
endmodule
